decade_count_ctrl: RTL and testbench

//  Sequencing controller for a chained BCD (mod-10 per digit) counter: start/stop/resume/ack

---
 rtl/decade_pkg.sv | 18 +
 rtl/bcd_digit.sv | 24 ++
 rtl/decade_count_ctrl.sv | 138 +++++++++++++
 tb/tb_decade_count_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/decade_pkg.sv
// Shared definitions for the decade counter controller slice.
package decade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Saturate a nibble to a legal BCD digit.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One mod-10 decade of the counter chain.
module bcd_digit
    import decade_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       load0,
    input  logic       en,
    output logic [3:0] q,
    output logic       at_max
);

    assign at_max = (q == BCD_MAX);

    // Digit register: zero on clear/load0, otherwise increment with 9->0 wrap.
    always_ff @(posedge clk) begin
        if (clear || load0) begin
            q <= '0;
        end else if (en) begin
            q <= at_max ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/decade_count_ctrl.sv
// Start/stop/resume/ack sequencer for a chained BCD counter with
// programmable terminal count and prescaled count tick.
module decade_count_ctrl
    import decade_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  ack,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   pre;
    logic [W-1:0]    limit_reg;
    logic [W-1:0]    limit_clamped;
    logic [W-1:0]    count_nx;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] en;
    logic            tick_int;
    logic            go_idle;
    logic            launch;

    // A stop in the same cycle as start always wins, so launch/resume require !stop.
    assign launch   = (state == ST_IDLE) && start && !stop;
    assign tick_int = (state == ST_RUN) && !stop && (pre == PRE_LAST);
    assign go_idle  = (state == ST_DONE) && ack;

    // Clamp every limit nibble to a legal digit before capture.
    always_comb begin
        limit_clamped = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            limit_clamped[4*i +: 4] = bcd_clamp(limit[4*i +: 4]);
        end
    end

    // Digit chain; count_nx mirrors the digit update so DONE can be entered
    // on the same edge the final value is written.
    assign en[0] = tick_int;
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i > 0) begin : g_carry
            assign en[i] = en[i-1] & at_max[i-1];
        end
        assign count_nx[4*i +: 4] = en[i] ? (at_max[i] ? 4'd0 : count[4*i +: 4] + 4'd1)
                                          : count[4*i +: 4];
        bcd_digit u_digit (
            .clk    (clk),
            .clear  (clear),
            .load0  (go_idle),
            .en     (en[i]),
            .q      (count[4*i +: 4]),
            .at_max (at_max[i])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_nx = (limit_clamped == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nx = ST_HOLD;
                end else if (tick_int && (count_nx == limit_reg)) begin
                    state_nx = ST_DONE;
                end
            end
            ST_HOLD: begin
                if (start && !stop) begin
                    state_nx = ST_RUN;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Prescaler: restarts on launch, advances only while running, frozen in HOLD.
    always_ff @(posedge clk) begin
        if (clear || launch) begin
            pre <= '0;
        end else if ((state == ST_RUN) && !stop) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
    end

    // Terminal count captured once at launch; later limit changes are ignored.
    always_ff @(posedge clk) begin
        if (clear) begin
            limit_reg <= '0;
        end else if (launch) begin
            limit_reg <= limit_clamped;
        end
    end

    // Registered tick pulse, aligned with the count update it reports.
    always_ff @(posedge clk) begin
        if (clear) begin
            tick <= 1'b0;
        end else begin
            tick <= tick_int;
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_HOLD);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_decade_count_ctrl.sv
// Directed self-checking bench for decade_count_ctrl (PRESCALE 1 and 3).
module tb_decade_count_ctrl;

    logic        clk = 1'b0;
    logic        clear, start, stop, ack;
    logic [15:0] limit;
    logic [15:0] count1, count3;
    logic        tick1, busy1, done1;
    logic        tick3, busy3, done3;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    decade_count_ctrl #(.DIGITS(4), .PRESCALE(1)) u_dut1 (
        .clk(clk), .clear(clear), .start(start), .stop(stop), .ack(ack),
        .limit(limit), .count(count1), .tick(tick1), .busy(busy1), .done(done1)
    );

    decade_count_ctrl #(.DIGITS(4), .PRESCALE(3)) u_dut3 (
        .clk(clk), .clear(clear), .start(start), .stop(stop), .ack(ack),
        .limit(limit), .count(count3), .tick(tick3), .busy(busy3), .done(done3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance n rising edges, settling 1 time unit after the last one.
    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] bcd16(input int unsigned v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        clear = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0; limit = '0;
        step(2);
        clear = 1'b0;
        check("rst_count1", count1, 16'h0000);
        check("rst_busy1",  busy1,  0);
        check("rst_done1",  done1,  0);
        check("rst_tick1",  tick1,  0);
        check("rst_count3", count3, 16'h0000);

        // Clear held two cycles while counting
        limit = 16'h0012; start = 1'b1; step(1); start = 1'b0;
        step(3);
        check("t1_pre_count", count1, 16'h0003);
        clear = 1'b1; step(2); clear = 1'b0;
        check("t1_count", count1, 16'h0000);
        check("t1_busy",  busy1,  0);
        check("t1_done",  done1,  0);
        check("t1_tick",  tick1,  0);

        // PRESCALE=1 up to 0012; limit input changed after capture
        limit = 16'h0012; start = 1'b1; step(1); start = 1'b0;
        limit = 16'h0005;
        check("t2_busy",  busy1,  1);
        check("t2_count0", count1, 16'h0000);
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check("t2_count", count1, bcd16(i));
            check("t2_tick",  tick1,  1);
        end
        check("t2_done",  done1, 1);
        check("t2_busy_done", busy1, 0);
        step(1);
        check("t2_hold_count", count1, 16'h0012);
        check("t2_hold_tick",  tick1,  0);
        ack = 1'b1; step(1); ack = 1'b0;
        check("t2_ack_count", count1, 16'h0000);
        check("t2_ack_done",  done1,  0);

        // Multi-digit carry up to 0105
        limit = 16'h0105; start = 1'b1; step(1); start = 1'b0;
        step(99);
        check("t3_0099", count1, 16'h0099);
        step(1);
        check("t3_0100", count1, 16'h0100);
        check("t3_tick", tick1,  1);
        step(4);
        check("t3_0104_done", done1, 0);
        step(1);
        check("t3_0105", count1, 16'h0105);
        check("t3_done", done1,  1);
        ack = 1'b1; step(1); ack = 1'b0;

        // PRESCALE=3: stop/hold/resume and start+stop in RUN
        clear = 1'b1; step(1); clear = 1'b0;
        limit = 16'h0020; start = 1'b1; step(1); start = 1'b0;
        step(20);
        check("t4_count6", count3, 16'h0006);
        step(1);
        check("t4_count7", count3, 16'h0007);
        check("t4_tick7",  tick3,  1);
        step(1);
        stop = 1'b1; step(1); stop = 1'b0;
        check("t4_hold_busy",  busy3,  1);
        check("t4_hold_count", count3, 16'h0007);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t4_frozen", count3, 16'h0007);
            check("t4_notick", tick3,  0);
        end
        start = 1'b1; step(1); start = 1'b0;
        check("t4_resume_count", count3, 16'h0007);
        step(1);
        check("t4_resume1", count3, 16'h0007);
        step(1);
        check("t4_count8", count3, 16'h0008);
        check("t4_tick8",  tick3,  1);
        step(2);
        check("t4_due", count3, 16'h0008);
        start = 1'b1; stop = 1'b1; step(1);
        check("t4_ss_count", count3, 16'h0008);
        check("t4_ss_tick",  tick3,  0);
        check("t4_ss_busy",  busy3,  1);
        step(1);
        check("t4_ss_hold", count3, 16'h0008);
        start = 1'b0; stop = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(1);
        check("t4_count9", count3, 16'h0009);

        // Zero limit, clamped limit, start+stop in IDLE
        clear = 1'b1; step(1); clear = 1'b0;
        limit = 16'h0000; start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        check("t5_ss_idle_busy", busy1, 0);
        check("t5_ss_idle_done", done1, 0);
        start = 1'b1; step(1); start = 1'b0;
        check("t5_zero_done",  done1,  1);
        check("t5_zero_count", count1, 16'h0000);
        check("t5_zero_tick",  tick1,  0);
        check("t5_zero_busy",  busy1,  0);
        ack = 1'b1; step(1); ack = 1'b0;
        check("t5_ack", done1, 0);
        limit = 16'h00A3; start = 1'b1; step(1); start = 1'b0;
        step(92);
        check("t5_0092", count1, 16'h0092);
        check("t5_0092_done", done1, 0);
        step(1);
        check("t5_0093", count1, 16'h0093);
        check("t5_0093_done", done1, 1);
        ack = 1'b1; step(1); ack = 1'b0;

        // Clear mid-run, ack in RUN and start/stop in DONE ignored
        limit = 16'h0099; start = 1'b1; step(1); start = 1'b0;
        step(42);
        check("t6_0042", count1, 16'h0042);
        ack = 1'b1; step(1); ack = 1'b0;
        check("t6_ack_run_count", count1, 16'h0043);
        check("t6_ack_run_busy",  busy1,  1);
        clear = 1'b1; step(1); clear = 1'b0;
        check("t6_clr_count", count1, 16'h0000);
        check("t6_clr_busy",  busy1,  0);
        limit = 16'h0003; start = 1'b1; step(1); start = 1'b0;
        step(3);
        check("t6_done", done1, 1);
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        check("t6_done_hold", done1,  1);
        check("t6_done_count", count1, 16'h0003);
        check("t6_done_busy", busy1,  0);
        ack = 1'b1; step(1); ack = 1'b0;
        check("t6_final_count", count1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
